serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Multi-cycle, parametrised N-bit subtractor: diff = a - b - bin.
- Built around a BPC-bit full-subtractor slice. The slice is reused every cycle, and a borrow flip-flop chains the slices together.
- Sequential successor to the single-bit gate-level full subtractor. Meant for area-constrained datapaths that can tolerate WIDTH/BPC cycles of latency.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 2.
- BPC, 1, bits processed per clock. Must divide WIDTH exactly. STEPS = WIDTH/BPC.

Ports:
- clk     input   1      rising-edge clock
- rst_n   input   1      asynchronous active-low reset
- start   input   1      request a subtraction; sampled only while busy = 0
- a       input   WIDTH  minuend; captured at the accepting edge
- b       input   WIDTH  subtrahend; captured at the accepting edge
- bin     input   1      borrow-in; captured at the accepting edge
- busy    output  1      operation in progress
- done    output  1      one-cycle pulse; diff/bout/ovf valid
- diff    output  WIDTH  difference, modulo 2^WIDTH
- bout    output  1      final borrow-out; 1 iff a < b + bin (unsigned)
- ovf     output  1      signed (two's-complement) overflow

Behaviour:

Reset (rst_n low):
- Asynchronous, immediate: state = IDLE.
- busy = 0, done = 0, diff = 0, bout = 0, ovf = 0.
- Step counter and borrow register = 0.
- Reset mid-operation aborts the operation. No done pulse is produced, and no partial result is visible.

State machine (2 states):
- IDLE: busy = 0.
  - start = 1 at a rising edge → capture a, b, bin into shift registers, borrow_reg = bin, cnt = 0, go to RUN, busy = 1 from that edge.
- RUN: busy = 1.
  - At each edge the slice takes the low BPC bits of the a- and b-shift registers plus borrow_reg and produces BPC difference bits and a borrow.
  - Operand registers shift right by BPC. Difference bits shift into the result register from the MSB side. borrow_reg takes the slice borrow. cnt increments.
  - On the edge where cnt reaches STEPS-1:
    - diff takes the completed result.
    - bout = the slice borrow.
    - ovf = (a_cap[MSB] != b_cap[MSB]) && (diff[MSB] != a_cap[MSB]), using the captured operands.
    - done = 1, busy = 0, state → IDLE.

Latency:
- start accepted at edge k → done = 1 in the cycle following edge k+STEPS.
- Throughput: one operation per STEPS+1 cycles minimum.

Output timing and stability:
- done is registered and high for exactly one cycle. It clears on the next edge.
- diff, bout and ovf are held stable from the done edge until the completion edge of the next operation. They do not change during RUN.
- The result register is internal and is not exposed during RUN.

Boundary conditions:
- start while busy = 1: ignored. Operands are not re-captured and the current operation is unaffected.
- start during the done cycle (busy = 0): accepted. The new operation begins and done still deasserts next cycle.
- a, b, bin changing after capture: no effect.
- Borrow chain: bin feeds the LSB slice only. Bits are never dropped. Wrap-around is modulo 2^WIDTH.
- BPC = WIDTH: STEPS = 1, so the result appears one edge after acceptance. The same handshake applies.

Test Plan:
1. WIDTH=8, BPC=1: a=0x05, b=0x03, bin=0, single start → after 8 RUN edges, diff=0x02, bout=0, ovf=0; done high one cycle; busy high exactly 8 cycles.
2. WIDTH=8, BPC=1:
   - a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0.
   - a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, ovf=0.
3. WIDTH=8, BPC=1:
   - a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1.
   - a=0x7F, b=0xFF, bin=0 → diff=0x80, bout=1, ovf=1.
4. WIDTH=8, BPC=1: start with a=0x10, b=0x01; assert start again with a=0xFF at cycle 3 → second request ignored; diff=0x0F. Then start on the done cycle with a=0x20, b=0x10 → accepted; diff=0x10 after 8 more cycles.
5. WIDTH=8, BPC=1: start, then pull rst_n low at RUN cycle 4 → busy, done, diff, bout and ovf go to 0 immediately. After release, a fresh a=0x09, b=0x04 completes correctly with diff=0x05.
6. WIDTH=4, BPC=2 (STEPS=2), and WIDTH=4, BPC=4: exhaustive over all a, b, bin (512 cases) against a reference model a-b-bin → diff, bout and ovf all match, with latency 2 and 1 respectively.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Multi-cycle N-bit subtractor computing diff = a - b - bin. A BPC-bit
// ripple-borrow slice is reused every clock; a borrow flip-flop carries the
// borrow between successive slices, LSB chunk first. Handshake is
// start / busy / done. diff, bout and ovf are registered and only update
// on the completion edge, so the partial result is never visible.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BPC;
  // Keep the counter at least one bit wide so STEPS = 1 still elaborates.
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [BPC-1:0]   w_d;
  logic [BPC:0]     w_bc;
  logic [WIDTH-1:0] w_full;
  logic             w_last;
  logic             w_ovf;

  // The slice: BPC full subtractors in a ripple-borrow chain. The incoming
  // borrow comes from the borrow register, so bin only ever reaches bit 0.
  assign w_bc[0] = r_borrow;

  genvar gi;
  generate
    for (gi = 0; gi < BPC; gi++) begin : g_slice
      assign w_d[gi]    = r_a_sh[gi] ^ r_b_sh[gi] ^ w_bc[gi];
      assign w_bc[gi+1] = (~r_a_sh[gi] & r_b_sh[gi])
                        | (~(r_a_sh[gi] ^ r_b_sh[gi]) & w_bc[gi]);
    end
  endgenerate

  // Result assembly. Earlier chunks are held in a shift register that only
  // needs WIDTH-BPC bits; the final chunk comes straight off the slice, so
  // w_full is the complete difference during the last RUN cycle.
  generate
    if (STEPS == 1) begin : g_res_one
      assign w_full = w_d;
    end else if (STEPS == 2) begin : g_res_two
      logic [BPC-1:0] r_res_sh;

      // Hold the single earlier chunk.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_res_sh <= '0;
        end else if (r_state == S_RUN) begin
          r_res_sh <= w_d;
        end
      end

      assign w_full = {w_d, r_res_sh};
    end else begin : g_res_many
      logic [WIDTH-BPC-1:0] r_res_sh;

      // New chunks enter at the MSB side and older ones move toward bit 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_res_sh <= '0;
        end else if (r_state == S_RUN) begin
          r_res_sh <= {w_d, r_res_sh[WIDTH-BPC-1:BPC]};
        end
      end

      assign w_full = {w_d, r_res_sh};
    end
  endgenerate

  assign w_last = (r_cnt == LAST_CNT);

  // Signed overflow: operands of different sign and the result sign differs
  // from the minuend. Uses the captured sign bits, not the live inputs.
  assign w_ovf = (r_a_msb != r_b_msb) && (w_full[WIDTH-1] != r_a_msb);

  // Control FSM plus operand shifting, borrow chaining and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh   <= r_a_sh >> BPC;
          r_b_sh   <= r_b_sh >> BPC;
          r_borrow <= w_bc[BPC];
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff  <= w_full;
            r_bout  <= w_bc[BPC];
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule
